// File: rtl/lcd_line_serializer_pkg.sv
// Shared types and constants for the memory-LCD line serializer.
// State encoding, mode-byte layout and trailer length live here so the top and bench agree.
package lcd_line_serializer_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StCsSetup,
        StMode,
        StAddr,
        StFetch,
        StData,
        StLtrail,
        StFtrail,
        StCsHold,
        StDone
    } state_e;

    localparam int unsigned BYTE_BITS      = 8;
    localparam int unsigned TRAILER_BITS   = 8;
    localparam int unsigned MODE_WRITE_BIT = 7;
    localparam int unsigned MODE_VCOM_BIT  = 6;

    function automatic logic [7:0] bit_reverse(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    function automatic logic [7:0] mode_byte(input logic vcom);
        logic [7:0] m;
        m                 = '0;
        m[MODE_WRITE_BIT] = 1'b1;
        m[MODE_VCOM_BIT]  = vcom;
        return m;
    endfunction

endpackage

// File: rtl/lcd_line_serializer_if.sv
// Control, pixel-FIFO read side and LCD pin bundle of the line serializer.
// Signal directions in the names are as seen from the serializer (master).
interface lcd_line_serializer_if;
    logic       i_start;
    logic       i_vcom;
    logic [7:0] i_fifo_rdata;
    logic       i_fifo_rempty;
    logic       o_fifo_rinc;
    logic       o_scs;
    logic       o_sclk;
    logic       o_si;
    logic       o_busy;
    logic       o_done;
    logic       o_underrun;

    modport master (
        input  i_start,
        input  i_vcom,
        input  i_fifo_rdata,
        input  i_fifo_rempty,
        output o_fifo_rinc,
        output o_scs,
        output o_sclk,
        output o_si,
        output o_busy,
        output o_done,
        output o_underrun
    );

    modport slave (
        output i_start,
        output i_vcom,
        output i_fifo_rdata,
        output i_fifo_rempty,
        input  o_fifo_rinc,
        input  o_scs,
        input  o_sclk,
        input  o_si,
        input  o_busy,
        input  o_done,
        input  o_underrun
    );
endinterface

// File: rtl/lcd_line_serializer_sclk_div.sv
// SCLK divider: each bit is CLK_DIV low cycles followed by CLK_DIV high cycles.
// Holds SCLK low and restarts at the low half whenever enable drops.
module lcd_line_serializer_sclk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_enable,
    output logic o_bit_end,
    output logic o_sclk
);
    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            high_q, high_d;
    logic            half_end;

    assign half_end = (cnt_q == CntW'(CLK_DIV - 1));

    always_comb begin
        cnt_d  = '0;
        high_d = 1'b0;
        if (i_enable) begin
            if (half_end) begin
                cnt_d  = '0;
                high_d = ~high_q;
            end else begin
                cnt_d  = cnt_q + CntW'(1);
                high_d = high_q;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q  <= '0;
            high_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            high_q <= high_d;
        end
    end

    assign o_bit_end = i_enable & high_q & half_end;
    assign o_sclk    = high_q;

endmodule

// File: rtl/lcd_line_serializer.sv
// Pops 1bpp bytes from the pixel FIFO and shifts one full memory-LCD frame out on SCS/SCLK/SI:
// mode byte, then per line address/data/trailer, then the frame trailer.
module lcd_line_serializer
    import lcd_line_serializer_pkg::*;
#(
    parameter int unsigned LINE_BYTES = 18,
    parameter int unsigned NUM_LINES  = 168,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned CS_SETUP   = 8
) (
    input logic                   i_clk,
    input logic                   i_reset_n,
    lcd_line_serializer_if.master bus
);
    localparam int unsigned LineW = $clog2(NUM_LINES + 1);
    localparam int unsigned ByteW = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
    localparam int unsigned WaitW = (CS_SETUP > 1) ? $clog2(CS_SETUP) : 1;

    state_e           state_q, state_d;
    logic [LineW-1:0] line_q, line_d;
    logic [ByteW-1:0] byte_q, byte_d;
    logic [2:0]       bit_q, bit_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [6:0]       sh_q, sh_d;
    logic             si_q, si_d;
    logic             scs_q, scs_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             underrun_q, underrun_d;
    logic             stall_q, stall_d;
    logic             pend_q, pend_d;
    logic             vcom_q, vcom_d;

    logic             bit_end;
    logic             sclk;
    logic             fifo_rinc;
    logic             load;
    logic [7:0]       load_byte;
    logic             bit_last;
    logic [LineW-1:0] line_next;

    lcd_line_serializer_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_enable  (en_q),
        .o_bit_end (bit_end),
        .o_sclk    (sclk)
    );

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        byte_d     = byte_q;
        bit_d      = bit_q;
        wait_d     = wait_q;
        sh_d       = sh_q;
        si_d       = si_q;
        scs_d      = scs_q;
        en_d       = en_q;
        busy_d     = busy_q;
        vcom_d     = vcom_q;
        done_d     = 1'b0;
        stall_d    = 1'b0;
        pend_d     = 1'b0;
        fifo_rinc  = 1'b0;
        load       = 1'b0;
        load_byte  = '0;
        line_next  = line_q + LineW'(1);
        bit_last   = (bit_q == ((state_q inside {StLtrail, StFtrail}) ?
                                3'(TRAILER_BITS - 1) : 3'(BYTE_BITS - 1)));

        unique case (state_q)
            StIdle: begin
                // done_q is only high in the first idle cycle; a start there is dropped
                if (bus.i_start && !done_q) begin
                    state_d = StCsSetup;
                    scs_d   = 1'b1;
                    busy_d  = 1'b1;
                    vcom_d  = bus.i_vcom;
                    line_d  = LineW'(1);
                    byte_d  = '0;
                    wait_d  = '0;
                end
            end
            StCsSetup: begin
                if (wait_q == WaitW'(CS_SETUP - 1)) begin
                    state_d   = StMode;
                    en_d      = 1'b1;
                    load      = 1'b1;
                    load_byte = bit_reverse(mode_byte(vcom_q));
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StMode, StAddr, StData, StLtrail, StFtrail: begin
                if (bit_end) begin
                    if (!bit_last) begin
                        bit_d = bit_q + 3'd1;
                        si_d  = sh_q[0];
                        sh_d  = {1'b0, sh_q[6:1]};
                    end else begin
                        unique case (state_q)
                            StMode: begin
                                state_d   = StAddr;
                                load      = 1'b1;
                                load_byte = 8'(line_q);
                            end
                            StAddr: begin
                                state_d = StFetch;
                                byte_d  = '0;
                                en_d    = 1'b0;
                            end
                            StData: begin
                                if (byte_q == ByteW'(LINE_BYTES - 1)) begin
                                    state_d = StLtrail;
                                    load    = 1'b1;
                                end else begin
                                    state_d = StFetch;
                                    byte_d  = byte_q + ByteW'(1);
                                    en_d    = 1'b0;
                                end
                            end
                            StLtrail: begin
                                load = 1'b1;
                                if (line_q == LineW'(NUM_LINES)) begin
                                    state_d = StFtrail;
                                end else begin
                                    state_d   = StAddr;
                                    line_d    = line_next;
                                    load_byte = 8'(line_next);
                                end
                            end
                            StFtrail: begin
                                state_d = StCsHold;
                                en_d    = 1'b0;
                                wait_d  = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            StFetch: begin
                // One pop in flight at most; the byte is loaded the cycle after the pop
                if (!pend_q) begin
                    if (!bus.i_fifo_rempty) begin
                        fifo_rinc = 1'b1;
                        pend_d    = 1'b1;
                    end else begin
                        stall_d = 1'b1;
                    end
                end else begin
                    state_d   = StData;
                    en_d      = 1'b1;
                    load      = 1'b1;
                    load_byte = bus.i_fifo_rdata;
                end
            end
            StCsHold: begin
                if (wait_q == WaitW'(CS_SETUP - 1)) begin
                    state_d = StDone;
                    scs_d   = 1'b0;
                    si_d    = 1'b0;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            si_d  = load_byte[0];
            sh_d  = load_byte[7:1];
            bit_d = '0;
        end

        underrun_d = stall_d & ~stall_q;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= StIdle;
            line_q     <= '0;
            byte_q     <= '0;
            bit_q      <= '0;
            wait_q     <= '0;
            sh_q       <= '0;
            si_q       <= 1'b0;
            scs_q      <= 1'b0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            stall_q    <= 1'b0;
            pend_q     <= 1'b0;
            vcom_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            byte_q     <= byte_d;
            bit_q      <= bit_d;
            wait_q     <= wait_d;
            sh_q       <= sh_d;
            si_q       <= si_d;
            scs_q      <= scs_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
            stall_q    <= stall_d;
            pend_q     <= pend_d;
            vcom_q     <= vcom_d;
        end
    end

    assign bus.o_fifo_rinc = fifo_rinc;
    assign bus.o_scs       = scs_q;
    assign bus.o_sclk      = sclk;
    assign bus.o_si        = si_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_underrun  = underrun_q;

endmodule

// File: tb/tb_lcd_line_serializer.sv
// Bench for lcd_line_serializer: a FIFO model feeds bytes, a pin monitor decodes SI on SCLK rises
// and each frame is compared against a bit list built straight from the frame format.
module tb_lcd_line_serializer;

    localparam int unsigned LB  = 2;
    localparam int unsigned NL  = 2;
    localparam int unsigned CD  = 2;
    localparam int unsigned CSS = 2;
    localparam int unsigned FB  = LB * NL;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lcd_line_serializer_if bus ();

    lcd_line_serializer #(
        .LINE_BYTES (LB),
        .NUM_LINES  (NL),
        .CLK_DIV    (CD),
        .CS_SETUP   (CSS)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    // FIFO model: data valid the cycle after a pop
    logic [7:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign bus.i_fifo_rempty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (bus.o_fifo_rinc === 1'b1) begin
            bus.i_fifo_rdata <= mem[rd_ptr];
            rd_ptr           <= rd_ptr + 1;
        end
    end

    // Pin monitor
    bit   cap_mem [0:4095];
    int   cap_cnt = 0;
    int   under_cnt = 0, done_cnt = 0;
    int   viol_rinc = 0, viol_si_stable = 0, viol_si_change = 0, viol_done = 0, viol_busy = 0;
    logic prev_sclk = 1'b0, prev_si = 1'b0, si_h1 = 1'b0, si_h2 = 1'b0;
    logic scs_h1 = 1'b0, scs_h2 = 1'b0;

    always @(negedge clk) begin
        if (bus.o_fifo_rinc === 1'b1 && bus.i_fifo_rempty === 1'b1) viol_rinc <= viol_rinc + 1;
        if (bus.o_sclk === 1'b1 && prev_sclk === 1'b0) begin
            if (bus.o_scs === 1'b1 && cap_cnt < 4096) begin
                cap_mem[cap_cnt] <= bus.o_si;
                cap_cnt          <= cap_cnt + 1;
            end
            if (bus.o_si !== si_h1 || bus.o_si !== si_h2) viol_si_stable <= viol_si_stable + 1;
        end
        if (bus.o_si !== prev_si && bus.o_sclk !== 1'b0) viol_si_change <= viol_si_change + 1;
        if (bus.o_underrun === 1'b1) under_cnt <= under_cnt + 1;
        if (bus.o_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            if (!(bus.o_scs === 1'b0 && scs_h1 === 1'b0 && scs_h2 === 1'b1))
                viol_done <= viol_done + 1;
        end
        if (bus.o_scs === 1'b1 && bus.o_busy !== 1'b1) viol_busy <= viol_busy + 1;
        prev_sclk <= bus.o_sclk;
        prev_si   <= bus.o_si;
        si_h1     <= bus.o_si;
        si_h2     <= si_h1;
        scs_h1    <= bus.o_scs;
        scs_h2    <= scs_h1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    // Reference frame built from the format rules
    bit exp_mem [0:255];
    int exp_len;

    task automatic add_bit(input bit v);
        exp_mem[exp_len] = v;
        exp_len++;
    endtask

    task automatic build_expected(input bit vcom, input int base);
        logic [7:0] a;
        logic [7:0] d;
        exp_len = 0;
        add_bit(1'b1);
        add_bit(vcom);
        repeat (6) add_bit(1'b0);
        for (int ln = 1; ln <= NL; ln++) begin
            a = 8'(ln);
            for (int i = 0; i < 8; i++) add_bit(a[i]);
            for (int b = 0; b < LB; b++) begin
                d = mem[base + (ln - 1) * LB + b];
                for (int i = 0; i < 8; i++) add_bit(d[i]);
            end
            repeat (8) add_bit(1'b0);
        end
        repeat (8) add_bit(1'b0);
    endtask

    task automatic compare_bits(input string tag, input int cap_base);
        int n;
        int first_bad;
        n         = cap_cnt - cap_base;
        first_bad = -1;
        check({tag, "_rises"}, n, exp_len);
        for (int i = 0; i < n && i < exp_len; i++) begin
            if (cap_mem[cap_base + i] != exp_mem[i] && first_bad < 0) first_bad = i;
        end
        check({tag, "_first_bad_bit"}, first_bad, -1);
    endtask

    task automatic start_frame(input bit vcom);
        bus.i_start = 1'b1;
        bus.i_vcom  = vcom;
        tick(1);
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int busy_low);
        int k;
        k        = 0;
        busy_low = 0;
        while (bus.o_done !== 1'b1 && k < 3000) begin
            if (bus.o_busy !== 1'b1) busy_low++;
            tick(1);
            k++;
        end
        check({tag, "_done_seen"}, bus.o_done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, cb, db, ub, bl, k, stall_bad;
        bit vc;
        logic si_hold;

        bus.i_start = 1'b0;
        bus.i_vcom  = 1'b0;
        #1 rst_n = 1'b0;
        tick(3);
        check("rst_scs", bus.o_scs, 0);
        check("rst_sclk", bus.o_sclk, 0);
        check("rst_si", bus.o_si, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_underrun", bus.o_underrun, 0);
        check("rst_rinc", bus.o_fifo_rinc, 0);
        rst_n = 1'b1;
        tick(2);

        // Case 1: pre-filled FIFO, vcom=1
        push(8'hA5); push(8'h3C); push(8'hFF); push(8'h00);
        base = rd_ptr; cb = cap_cnt; db = done_cnt; ub = under_cnt;
        start_frame(1'b1);
        check("c1_busy_after_start", bus.o_busy, 1);
        wait_done("c1", bl);
        check("c1_busy_low_cycles", bl, 0);
        check("c1_scs_at_done", bus.o_scs, 0);
        tick(2);
        build_expected(1'b1, base);
        compare_bits("c1", cb);
        check("c1_pops", rd_ptr - base, FB);
        check("c1_done_pulses", done_cnt - db, 1);
        check("c1_underruns", under_cnt - ub, 0);

        // Case 2: FIFO runs dry before the second byte
        push(8'hA5);
        base = rd_ptr; cb = cap_cnt; db = done_cnt; ub = under_cnt;
        start_frame(1'b1);
        k = 0;
        while (under_cnt == ub && k < 1000) begin tick(1); k++; end
        check("c2_underrun_seen", under_cnt - ub, 1);
        stall_bad = 0;
        si_hold   = bus.o_si;
        for (int i = 0; i < 50; i++) begin
            if (bus.o_sclk !== 1'b0 || bus.o_scs !== 1'b1 || bus.o_si !== si_hold) stall_bad++;
            tick(1);
        end
        check("c2_stall_pins", stall_bad, 0);
        push(8'h3C); push(8'hFF); push(8'h00);
        wait_done("c2", bl);
        tick(2);
        build_expected(1'b1, base);
        compare_bits("c2", cb);
        check("c2_underrun_pulses", under_cnt - ub, 1);
        check("c2_pops", rd_ptr - base, FB);

        // Case 3: start re-pulsed mid-frame and on the done cycle
        for (int i = 0; i < FB; i++) push(8'($urandom));
        base = rd_ptr; cb = cap_cnt; db = done_cnt;
        start_frame(1'b1);
        tick(60);
        check("c3_busy_mid1", bus.o_busy, 1);
        start_frame(1'b0);
        tick(100);
        check("c3_busy_mid2", bus.o_busy, 1);
        start_frame(1'b0);
        wait_done("c3", bl);
        check("c3_busy_low_cycles", bl, 0);
        bus.i_start = 1'b1;
        tick(1);
        bus.i_start = 1'b0;
        tick(3);
        check("c3_start_on_done_busy", bus.o_busy, 0);
        check("c3_start_on_done_scs", bus.o_scs, 0);
        build_expected(1'b1, base);
        compare_bits("c3", cb);
        check("c3_done_pulses", done_cnt - db, 1);

        // Case 4: asynchronous reset during DATA, then a clean frame
        for (int i = 0; i < FB; i++) push(8'($urandom));
        base = rd_ptr; db = done_cnt;
        start_frame(1'($urandom));
        k = 0;
        while (rd_ptr == base && k < 1000) begin tick(1); k++; end
        tick(5);
        #2 rst_n = 1'b0;
        #1;
        check("c4_abort_scs", bus.o_scs, 0);
        check("c4_abort_sclk", bus.o_sclk, 0);
        check("c4_abort_si", bus.o_si, 0);
        check("c4_abort_busy", bus.o_busy, 0);
        tick(5);
        rst_n = 1'b1;
        tick(3);
        check("c4_no_done_on_abort", done_cnt - db, 0);
        for (int i = 0; i < FB; i++) push(8'($urandom));
        vc   = 1'($urandom);
        base = rd_ptr; cb = cap_cnt; db = done_cnt;
        start_frame(vc);
        wait_done("c4", bl);
        tick(2);
        build_expected(vc, base);
        compare_bits("c4", cb);
        check("c4_pops", rd_ptr - base, FB);

        // Case 6 and random frames: vcom sampled at start even if it toggles later
        for (int r = 0; r < 3; r++) begin
            vc = (r == 0) ? 1'b0 : 1'($urandom);
            for (int i = 0; i < FB; i++) push(8'($urandom));
            base = rd_ptr; cb = cap_cnt; db = done_cnt;
            start_frame(vc);
            tick(20 + int'($urandom_range(0, 40)));
            bus.i_vcom = ~vc;
            wait_done($sformatf("rnd%0d", r), bl);
            tick(2);
            build_expected(vc, base);
            compare_bits($sformatf("rnd%0d", r), cb);
            check($sformatf("rnd%0d_done_pulses", r), done_cnt - db, 1);
        end

        check("inv_rinc_while_empty", viol_rinc, 0);
        check("inv_si_stable_before_rise", viol_si_stable, 0);
        check("inv_si_change_sclk_high", viol_si_change, 0);
        check("inv_done_after_scs_fall", viol_done, 0);
        check("inv_scs_without_busy", viol_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
